// File: rtl/shifter_serializer.sv
// rtl/shifter_serializer.sv - parallel-to-serial stage with valid/ready on both sides
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), asynchronous active-low reset
//   i_pvalid/o_pready/i_pdata parallel word handshake (WIDTH bits)
//   o_svalid/i_sready/o_sdata serial bit handshake, one bit per accepted beat
//   o_slast                   current serial bit is the final bit of the word
//   o_busy                    a word is loaded and not fully emitted
//   o_word_done               one-cycle pulse in the cycle after the final beat
module shifter_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pvalid,
    output logic             o_pready,
    input  logic [WIDTH-1:0] i_pdata,
    output logic             o_svalid,
    input  logic             i_sready,
    output logic             o_sdata,
    output logic             o_slast,
    output logic             o_busy,
    output logic             o_word_done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             word_done_q, word_done_d;

    logic last_bit;
    logic beat;
    logic load;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
        end
    end

    always_comb begin
        last_bit    = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
        beat        = (state_q == SHIFT) && i_sready;
        // Ready in the final-beat cycle lets the next word load with no bubble.
        o_pready    = (state_q == IDLE) || (last_bit && i_sready);
        load        = i_pvalid && o_pready;

        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        word_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d = i_pdata;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (LSB_FIRST) begin
                        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (last_bit) begin
                        word_done_d = 1'b1;
                        // Counter is cleared explicitly so it never wraps.
                        cnt_d       = '0;
                        if (load) begin
                            shreg_d = i_pdata;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_svalid    = (state_q == SHIFT);
    assign o_busy      = (state_q == SHIFT);
    assign o_slast     = last_bit;
    assign o_sdata     = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    assign o_word_done = word_done_q;

endmodule

// File: tb/tb_shifter_serializer.sv
// tb/tb_shifter_serializer.sv - self-checking bench for shifter_serializer
module tb_shifter_serializer;

    logic       clk;
    logic       rst_n;
    logic       pvalid    [2];
    logic [7:0] pdata     [2];
    logic       sready    [2];
    logic       pready    [2];
    logic       svalid    [2];
    logic       sdata     [2];
    logic       slast     [2];
    logic       busy      [2];
    logic       word_done [2];

    int checks = 0;
    int errors = 0;

    // Index 1: LSB-first instance, index 0: MSB-first instance.
    shifter_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_pvalid(pvalid[1]), .o_pready(pready[1]), .i_pdata(pdata[1]),
        .o_svalid(svalid[1]), .i_sready(sready[1]), .o_sdata(sdata[1]),
        .o_slast(slast[1]), .o_busy(busy[1]), .o_word_done(word_done[1])
    );

    shifter_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_pvalid(pvalid[0]), .o_pready(pready[0]), .i_pdata(pdata[0]),
        .o_svalid(svalid[0]), .i_sready(sready[0]), .o_sdata(sdata[0]),
        .o_slast(slast[0]), .o_busy(busy[0]), .o_word_done(word_done[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream universal shift register, select = right shift on each beat.
    logic [7:0] usr;
    logic       usr_clr;
    always @(posedge clk) begin
        if (usr_clr) usr <= 8'h00;
        else if (svalid[1] && sready[1]) usr <= {sdata[1], usr[7:1]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, " pready"},    32'(pready[d]),    32'd1);
        check({tag, " svalid"},    32'(svalid[d]),    32'd0);
        check({tag, " sdata"},     32'(sdata[d]),     32'd0);
        check({tag, " slast"},     32'(slast[d]),     32'd0);
        check({tag, " busy"},      32'(busy[d]),      32'd0);
        check({tag, " word_done"}, 32'(word_done[d]), 32'd0);
    endtask

    // seq holds the expected emitted bits, first bit in seq[7].
    task automatic send_word(input int d, input logic [7:0] word, input logic [7:0] seq);
        @(negedge clk);
        check("accept pready", 32'(pready[d]), 32'd1);
        sready[d] = 1'b1;
        pvalid[d] = 1'b1;
        pdata[d]  = word;
        usr_clr   = 1'b1;
        @(negedge clk);
        pvalid[d] = 1'b0;
        pdata[d]  = ~word;
        usr_clr   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("w%02h bit%0d sdata", word, i), 32'(sdata[d]), 32'(seq[7-i]));
            check($sformatf("w%02h bit%0d svalid", word, i), 32'(svalid[d]), 32'd1);
            check($sformatf("w%02h bit%0d slast", word, i), 32'(slast[d]), 32'(i == 7));
            check($sformatf("w%02h bit%0d pready", word, i), 32'(pready[d]), 32'(i == 7));
            check($sformatf("w%02h bit%0d busy", word, i), 32'(busy[d]), 32'd1);
            @(negedge clk);
        end
        check($sformatf("w%02h word_done", word), 32'(word_done[d]), 32'd1);
        check($sformatf("w%02h end svalid", word), 32'(svalid[d]), 32'd0);
        check($sformatf("w%02h end busy", word), 32'(busy[d]), 32'd0);
        check($sformatf("w%02h end pready", word), 32'(pready[d]), 32'd1);
        if (d == 1) check($sformatf("w%02h usr", word), 32'(usr), 32'(word));
        @(negedge clk);
        check($sformatf("w%02h word_done pulse", word), 32'(word_done[d]), 32'd0);
    endtask

    typedef struct {
        int         d;
        logic [7:0] word;
        logic [7:0] seq;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [7:0] rebuilt;
        logic       prev_stall;
        logic       prev_sdata;
        logic       prev_slast;
        int         beats;
        int         cyc;
        logic [15:0] b2b_seq;

        vecs[0] = '{1, 8'hA5, 8'b10100101};
        vecs[1] = '{0, 8'hA5, 8'b10100101};
        vecs[2] = '{0, 8'h80, 8'b10000000};
        vecs[3] = '{1, 8'h00, 8'b00000000};
        vecs[4] = '{1, 8'hFF, 8'b11111111};
        vecs[5] = '{1, 8'h5A, 8'b01011010};
        vecs[6] = '{1, 8'hC1, 8'b10000011};
        vecs[7] = '{0, 8'h01, 8'b00000001};
        vecs[8] = '{0, 8'hC1, 8'b11000001};

        for (int d = 0; d < 2; d++) begin
            pvalid[d] = 1'b0;
            pdata[d]  = 8'h00;
            sready[d] = 1'b1;
        end
        usr_clr = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset svalid", 32'(svalid[1]), 32'd0);
        check("reset busy",   32'(busy[1]),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(1, "post-reset lsb");
        check_idle(0, "post-reset msb");

        foreach (vecs[k]) send_word(vecs[k].d, vecs[k].word, vecs[k].seq);

        // Back-to-back: 0x0F then 0xF0 with no idle beat.
        b2b_seq = 16'b1111000000001111;
        @(negedge clk);
        check("b2b idle pready", 32'(pready[1]), 32'd1);
        pvalid[1] = 1'b1;
        pdata[1]  = 8'h0F;
        sready[1] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            if (k == 0) pdata[1] = 8'hF0;
            if (k == 8) begin
                pvalid[1] = 1'b0;
                check("b2b first word_done", 32'(word_done[1]), 32'd1);
            end
            check($sformatf("b2b bit%0d sdata", k), 32'(sdata[1]), 32'(b2b_seq[15-k]));
            check($sformatf("b2b bit%0d svalid", k), 32'(svalid[1]), 32'd1);
            check($sformatf("b2b bit%0d pready", k), 32'(pready[1]), 32'(k == 7 || k == 15));
            check($sformatf("b2b bit%0d slast", k), 32'(slast[1]), 32'(k == 7 || k == 15));
            @(negedge clk);
        end
        check("b2b second word_done", 32'(word_done[1]), 32'd1);
        check("b2b end svalid", 32'(svalid[1]), 32'd0);

        // Backpressure on 0x3C with i_pdata churn while shifting.
        @(negedge clk);
        pvalid[1] = 1'b1;
        pdata[1]  = 8'h3C;
        @(negedge clk);
        beats      = 0;
        cyc        = 0;
        rebuilt    = 8'h00;
        prev_stall = 1'b0;
        prev_sdata = 1'b0;
        prev_slast = 1'b0;
        while (beats < 8 && cyc < 200) begin
            if (prev_stall) begin
                check("stall sdata stable", 32'(sdata[1]), 32'(prev_sdata));
                check("stall slast stable", 32'(slast[1]), 32'(prev_slast));
            end
            sready[1] = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            pvalid[1] = !slast[1];
            pdata[1]  = 8'($urandom_range(0, 255));
            if (svalid[1] && sready[1]) begin
                rebuilt[beats] = sdata[1];
                beats++;
            end
            prev_stall = svalid[1] && !sready[1];
            prev_sdata = sdata[1];
            prev_slast = slast[1];
            cyc++;
            @(negedge clk);
        end
        pvalid[1] = 1'b0;
        sready[1] = 1'b1;
        check("bp beat count", 32'(beats), 32'd8);
        check("bp rebuilt word", 32'(rebuilt), 32'h3C);
        check("bp word_done", 32'(word_done[1]), 32'd1);
        check("bp end svalid", 32'(svalid[1]), 32'd0);

        // Reset after 3 of 8 bits of 0xFF.
        @(negedge clk);
        pvalid[1] = 1'b1;
        pdata[1]  = 8'hFF;
        @(negedge clk);
        pvalid[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", 32'(busy[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset svalid",    32'(svalid[1]),    32'd0);
        check("mid reset sdata",     32'(sdata[1]),     32'd0);
        check("mid reset slast",     32'(slast[1]),     32'd0);
        check("mid reset busy",      32'(busy[1]),      32'd0);
        check("mid reset word_done", 32'(word_done[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(1, "after mid reset");
        send_word(1, 8'h01, 8'b10000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shifter_serializer.md
Name:
shifter_serializer

Overview:
- Parallel-to-serial stage that drives a serial line into a downstream universal shift register's serial input (right-shift port for LSB-first, left-shift port for MSB-first).
- Accepts WIDTH-bit words on a valid/ready handshake, then emits them one bit per accepted serial beat, with its own valid/ready handshake and a last-bit marker.
- Supports back-to-back words with no idle beat between them.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- LSB_FIRST, 1, 1 = emit bit 0 first; 0 = emit bit WIDTH-1 first.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_pvalid  input  1  parallel word valid.
- o_pready  output  1  parallel word ready.
- i_pdata  input  WIDTH  parallel word.
- o_svalid  output  1  serial bit valid.
- i_sready  input  1  downstream accepts serial bit.
- o_sdata  output  1  current serial bit.
- o_slast  output  1  current bit is the final bit of the word.
- o_busy  output  1  a word is loaded and not fully emitted.
- o_word_done  output  1  one-cycle pulse, registered, in the cycle after the last bit is accepted.

Behaviour:
- Reset (asynchronous, i_rst_n low; clock i_clk): state IDLE, shift register 0, bit counter 0.
  - Output reset values: o_svalid 0, o_sdata 0, o_slast 0, o_busy 0, o_word_done 0.
  - o_pready is 1 once reset is released.
  - Reset mid-word discards the word; no partial bits are emitted after release.
- FSM states: IDLE, SHIFT.
- IDLE:
  - o_pready = 1, o_svalid = 0.
  - On i_pvalid && o_pready: load i_pdata into the shift register, clear the counter, go to SHIFT.
  - Bit 0 (or bit WIDTH-1) is on o_sdata with o_svalid = 1 in the next cycle. Latency from word accept to first valid bit is 1 cycle.
- SHIFT:
  - o_svalid = 1, o_busy = 1.
  - o_sdata = shreg[0] when LSB_FIRST, else shreg[WIDTH-1].
  - o_slast = 1 when counter == WIDTH-1.
- Serial beat (o_svalid && i_sready):
  - Shift the register (right if LSB_FIRST, left otherwise), zero-filling.
  - Increment the counter.
- No beat (i_sready = 0): o_sdata, o_slast and all state hold. o_sdata must stay stable while o_svalid && !i_sready.
- Final beat (o_slast && i_sready):
  - o_pready = 1 combinationally in that cycle.
  - If i_pvalid is also 1: load the new word, clear the counter, stay in SHIFT. The next word's first bit follows in the very next cycle (zero bubble).
  - Otherwise: return to IDLE.
  - o_word_done pulses 1 in the following cycle in both cases.
- o_pready = 0 during SHIFT except in the final-beat cycle.
- Input changes without a handshake are ignored.
- Counter width: $clog2(WIDTH). Counter never exceeds WIDTH-1 and does not wrap within a word.
- Throughput: one word per WIDTH cycles with continuous i_pvalid and i_sready.
- o_sdata is combinational from the register, so no glitch-free requirement applies. All other outputs except o_pready are registered or derived from registered state.

Test Plan:
- WIDTH=8, LSB_FIRST=1, i_sready held 1, word 0xA5 → o_sdata sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles, o_slast only on the 8th, o_word_done one cycle later, back to IDLE.
- LSB_FIRST=0, word 0xA5 → sequence 1,0,1,0,0,1,0,1 (MSB first); word 0x80 → 1 then seven 0s.
- Back-to-back: i_pvalid held with 0x0F then 0xF0, i_sready 1 → 16 contiguous valid bits 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1, no gap, o_pready high only in cycles where o_slast=1 and in the initial IDLE cycle.
- Backpressure: i_sready toggled pseudo-randomly, 0x3C → o_sdata/o_slast stable while stalled; the reconstructed word equals 0x3C; i_pdata changes during SHIFT are ignored.
- Reset after 3 of 8 bits of 0xFF → all outputs 0 immediately. After release: IDLE, o_pready 1. Next word 0x01 is emitted cleanly with no residual bits.
- Connect to a universal shift register with select = right shift on each beat (LSB_FIRST=1) → its parallel output equals the sent word after the last beat, for 0x00, 0xFF and 0x5A.
